// File: rtl/memresp_gen_pkg.sv
// Shared definitions for the write-response generator.
// Holds the default packet magic, the one-hot FSM encodings, the byte2 field
// positions, the BRESP codes, the queued-command layout and two small helpers.
package memresp_gen_pkg;

    localparam logic [7:0] DEF_RESP_MAGIC = 8'hA5;

    // One-hot FSM encodings
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_SEND = 3'b100
    } state_t;

    // byte2 = {tid, to, mis, resp}
    localparam int unsigned B2_TID_MSB  = 7;
    localparam int unsigned B2_TID_LSB  = 4;
    localparam int unsigned B2_TO       = 3;
    localparam int unsigned B2_MIS      = 2;
    localparam int unsigned B2_RESP_MSB = 1;
    localparam int unsigned B2_RESP_LSB = 0;

    // AXI BRESP codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // Queued write command
    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] len;
        logic [3:0] tid;
    } req_entry_t;

    localparam int unsigned REQ_W = 20;

    function automatic logic [7:0] pack_status(logic [3:0] tid, logic to, logic mis,
                                               logic [1:0] resp);
        logic [7:0] b;
        b = '0;
        b[B2_TID_MSB:B2_TID_LSB]   = tid;
        b[B2_TO]                   = to;
        b[B2_MIS]                  = mis;
        b[B2_RESP_MSB:B2_RESP_LSB] = resp;
        return b;
    endfunction

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/memresp_fifo.sv
// Synchronous FIFO holding pending write commands.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push, wdata write side; a push while full is ignored
//   pop, rdata  read side; rdata is the current head (show-ahead)
//   empty       no entries stored
//   empty_next  no entries after this cycle's push/pop
//   full_next   DEPTH entries after this cycle's push/pop
module memresp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             empty_next,
    output logic             full_next
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_CNT);
    assign do_pop  = pop && (count != '0);

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    assign rdata      = mem[rd_ptr];
    assign empty      = (count == '0);
    assign empty_next = (count_next == '0);
    assign full_next  = (count_next == FULL_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/memresp_gen.sv
// Write-response packet generator (bus_clock domain).
// Queues write commands, pairs each head command with its in-order write
// completion (or a watchdog timeout) and serialises a 4-byte status packet
// {RESP_MAGIC, cmd, {tid,to,mis,resp}, len} onto an 8-bit AXI-Stream.
// Ports:
//   bus_clock, bus_reset               clock, synchronous active-high reset
//   req_valid/req_ready/req_cmd/len/tid  command input (req_ready registered)
//   cpl_valid/cpl_ready/cpl_tid/resp   write completion (AXI B) input
//   m_tvalid/m_tready/m_tkeep/m_tlast/m_tdata  response stream
//   err_count                          saturating count of timeout, mismatch and drop events
module memresp_gen
    import memresp_gen_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [7:0]  RESP_MAGIC = DEF_RESP_MAGIC
) (
    input  logic       bus_clock,
    input  logic       bus_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [7:0] req_len,
    input  logic [3:0] req_tid,
    input  logic       cpl_valid,
    output logic       cpl_ready,
    input  logic [3:0] cpl_tid,
    input  logic [1:0] cpl_resp,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tkeep,
    output logic       m_tlast,
    output logic [7:0] m_tdata,
    output logic [7:0] err_count
);
    localparam int unsigned   WW        = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    req_entry_t       head;
    logic [REQ_W-1:0] q_rdata;
    logic             q_push;
    logic             q_pop;
    logic             q_empty;
    logic             q_empty_next;
    logic             q_full_next;

    state_t           state;
    logic [WW-1:0]    wdog;
    logic [1:0]       beat;
    logic [7:0]       status;
    logic             cpl_hs;
    logic             out_hs;
    logic             mis;

    assign q_push  = req_valid && req_ready;
    assign out_hs  = m_tvalid && m_tready;
    assign q_pop   = (state == ST_SEND) && (beat == 2'd3) && out_hs;
    assign cpl_hs  = cpl_valid && cpl_ready;
    assign head    = req_entry_t'(q_rdata);
    assign mis     = (cpl_tid != head.tid);
    assign m_tkeep = m_tvalid;

    memresp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk        (bus_clock),
        .rst        (bus_reset),
        .push       (q_push),
        .wdata      ({req_cmd, req_len, req_tid}),
        .pop        (q_pop),
        .rdata      (q_rdata),
        .empty      (q_empty),
        .empty_next (q_empty_next),
        .full_next  (q_full_next)
    );

    always_ff @(posedge bus_clock) begin
        if (bus_reset) begin
            state     <= ST_IDLE;
            wdog      <= '0;
            beat      <= '0;
            status    <= '0;
            req_ready <= 1'b0;
            cpl_ready <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tdata   <= '0;
            err_count <= '0;
        end else begin
            // Registered as !full_next so a full queue never accepts, even while popping
            req_ready <= !q_full_next;
            unique case (state)
                ST_IDLE: begin
                    cpl_ready <= 1'b1;
                    // Completion with no queued command has no owner
                    if (cpl_hs) begin
                        err_count <= sat_inc8(err_count);
                    end
                    if (!q_empty) begin
                        state <= ST_WAIT;
                        wdog  <= '0;
                    end
                end
                ST_WAIT: begin
                    // A handshake on the last watchdog cycle takes priority
                    if (cpl_hs || (wdog == WDOG_LAST)) begin
                        state     <= ST_SEND;
                        cpl_ready <= 1'b0;
                        beat      <= 2'd0;
                        m_tvalid  <= 1'b1;
                        m_tlast   <= 1'b0;
                        m_tdata   <= RESP_MAGIC;
                        if (cpl_hs) begin
                            status <= pack_status(head.tid, 1'b0, mis, cpl_resp);
                            if (mis) begin
                                err_count <= sat_inc8(err_count);
                            end
                        end else begin
                            status    <= pack_status(head.tid, 1'b1, 1'b0, BRESP_SLVERR);
                            err_count <= sat_inc8(err_count);
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (out_hs) begin
                        unique case (beat)
                            2'd0: begin
                                beat    <= 2'd1;
                                m_tdata <= head.cmd;
                            end
                            2'd1: begin
                                beat    <= 2'd2;
                                m_tdata <= status;
                            end
                            2'd2: begin
                                beat    <= 2'd3;
                                m_tdata <= head.len;
                                m_tlast <= 1'b1;
                            end
                            default: begin
                                beat      <= 2'd0;
                                m_tvalid  <= 1'b0;
                                m_tlast   <= 1'b0;
                                m_tdata   <= '0;
                                cpl_ready <= 1'b1;
                                wdog      <= '0;
                                state     <= q_empty_next ? ST_IDLE : ST_WAIT;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memresp_gen.sv
module tb_memresp_gen;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic       bus_clock = 1'b0;
    logic       bus_reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_cmd   = '0;
    logic [7:0] req_len   = '0;
    logic [3:0] req_tid   = '0;
    logic       cpl_valid = 1'b0;
    logic       cpl_ready;
    logic [3:0] cpl_tid   = '0;
    logic [1:0] cpl_resp  = '0;
    logic       m_tvalid;
    logic       m_tready  = 1'b0;
    logic       m_tkeep;
    logic       m_tlast;
    logic [7:0] m_tdata;
    logic [7:0] err_count;

    int errors    = 0;
    int checks    = 0;
    int model_err = 0;

    memresp_gen #(
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .RESP_MAGIC (8'hA5)
    ) dut (
        .bus_clock (bus_clock),
        .bus_reset (bus_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .req_tid   (req_tid),
        .cpl_valid (cpl_valid),
        .cpl_ready (cpl_ready),
        .cpl_tid   (cpl_tid),
        .cpl_resp  (cpl_resp),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tdata   (m_tdata),
        .err_count (err_count)
    );

    always #5 bus_clock = ~bus_clock;

    // Reference: packet contents straight from the packet layout rules
    function automatic logic [31:0] exp_pkt(logic [7:0] c, logic [7:0] l, logic [3:0] t,
                                            bit to, bit mis, logic [1:0] r);
        int b2;
        b2 = int'(t) * 16 + (to ? 8 : 0) + (mis ? 4 : 0) + int'(r);
        return {8'hA5, c, 8'(b2), l};
    endfunction

    function automatic int err_inc(int v, int n);
        return (v + n > 255) ? 255 : v + n;
    endfunction

    task automatic step();
        @(posedge bus_clock);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] l, input logic [3:0] t,
                        output logic acc);
        req_valid = 1'b1;
        req_cmd   = c;
        req_len   = l;
        req_tid   = t;
        acc       = req_ready;
        step();
        req_valid = 1'b0;
    endtask

    // Returns right after the handshake edge; ok=0 if never accepted
    task automatic send_cpl(input logic [3:0] t, input logic [1:0] r, output logic ok);
        ok        = 1'b0;
        cpl_valid = 1'b1;
        cpl_tid   = t;
        cpl_resp  = r;
        for (int i = 0; i < 40; i++) begin
            if (cpl_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        cpl_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: ready on odd cycles, 2: random ready
    task automatic collect(input int mode, output logic [31:0] pkt, output logic fmt_ok,
                           output logic got);
        int         idx;
        logic       held;
        logic [7:0] held_data;
        logic       held_last;
        logic       rdy;
        idx = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
        fmt_ok = 1'b1; pkt = '0;
        for (int cyc = 0; cyc < 200 && idx < 4; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_tready = rdy;
            if (m_tkeep !== m_tvalid) fmt_ok = 1'b0;
            if (m_tvalid) begin
                if (held && (m_tdata !== held_data || m_tlast !== held_last)) fmt_ok = 1'b0;
                if (m_tlast !== (idx == 3)) fmt_ok = 1'b0;
                if (rdy) begin
                    pkt  = {pkt[23:0], m_tdata};
                    idx++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = m_tdata;
                    held_last = m_tlast;
                end
            end else if (held) begin
                fmt_ok = 1'b0;
            end
            step();
        end
        m_tready = 1'b0;
        got      = (idx == 4);
    endtask

    task automatic test_reset();
        bus_reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({m_tvalid, m_tkeep, m_tlast, req_ready, cpl_ready} !== 5'b0 || m_tdata !== 8'h00
            || err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got v/k/l/rr/cr=%b%b%b%b%b data=%h err=%h required all 0",
                     m_tvalid, m_tkeep, m_tlast, req_ready, cpl_ready, m_tdata, err_count);
        end
        bus_reset = 1'b0;
        step();
        checks++;
        if (req_ready !== 1'b1 || cpl_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got req_ready=%b cpl_ready=%b required 1/1",
                     req_ready, cpl_ready);
        end
    endtask

    task automatic test_basic();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        push(8'h05, 8'h0F, 4'd3, acc);
        step(); step();
        send_cpl(4'd3, 2'b00, ok);
        checks++;
        if (!acc || !ok || m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
            errors++;
            $display("FAIL basic_latency got acc=%b ok=%b tvalid=%b tdata=%h required 1/1/1/a5",
                     acc, ok, m_tvalid, m_tdata);
        end
        collect(0, pkt, fmt, got);
        checks++;
        if (!got || !fmt || pkt !== 32'hA505300F) begin
            errors++;
            $display("FAIL basic_packet got %h fmt=%b got=%b required a505300f", pkt, fmt, got);
        end
        checks++;
        if (err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL basic_err got %0d required %0d", err_count, model_err);
        end
    endtask

    task automatic test_timeout();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        int k;
        push(8'h11, 8'h22, 4'd2, acc);
        k = 0;
        while (!m_tvalid && k < 60) begin
            step();
            k++;
        end
        // 1 edge to leave ST_IDLE, 16 wait cycles (0..15), then byte0
        checks++;
        if (k != 17) begin
            errors++;
            $display("FAIL timeout_latency got %0d cycles required 17", k);
        end
        collect(0, pkt, fmt, got);
        model_err = err_inc(model_err, 1);
        checks++;
        if (!got || !fmt || pkt !== exp_pkt(8'h11, 8'h22, 4'd2, 1, 0, 2'b10)) begin
            errors++;
            $display("FAIL timeout_packet got %h required %h", pkt,
                     exp_pkt(8'h11, 8'h22, 4'd2, 1, 0, 2'b10));
        end
        checks++;
        if (err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL timeout_err got %0d required %0d", err_count, model_err);
        end
        // Late completion for tid 2 pairs with the next head
        push(8'h33, 8'h44, 4'd6, acc);
        step(); step();
        send_cpl(4'd2, 2'b00, ok);
        collect(0, pkt, fmt, got);
        model_err = err_inc(model_err, 1);
        checks++;
        if (!ok || !got || pkt !== exp_pkt(8'h33, 8'h44, 4'd6, 0, 1, 2'b00)
            || err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL late_cpl got %h err=%0d required %h err=%0d", pkt, err_count,
                     exp_pkt(8'h33, 8'h44, 4'd6, 0, 1, 2'b00), model_err);
        end
    endtask

    task automatic test_mismatch();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        push(8'h5A, 8'hC3, 4'd1, acc);
        step(); step();
        send_cpl(4'd4, 2'b10, ok);
        collect(0, pkt, fmt, got);
        model_err = err_inc(model_err, 1);
        checks++;
        if (!ok || !got || pkt !== 32'hA55A16C3) begin
            errors++;
            $display("FAIL mismatch_packet got %h required a55a16c3", pkt);
        end
        checks++;
        if (err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL mismatch_err got %0d required %0d", err_count, model_err);
        end
    endtask

    task automatic test_full();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        logic [4:0] accs;
        int vcnt;
        for (int i = 0; i < 5; i++) begin
            push(8'h40 + 8'(i), 8'h80 + 8'(i), 4'(i + 1), acc);
            accs[i] = acc;
            if (i == 3) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready got %b required 0", req_ready);
                end
            end
        end
        checks++;
        if (accs !== 5'b01111) begin
            errors++;
            $display("FAIL full_accept got %b required 01111", accs);
        end
        for (int i = 0; i < 4; i++) begin
            send_cpl(4'(i + 1), 2'(i), ok);
            checks++;
            if (!ok || m_tvalid !== 1'b1 || m_tdata !== 8'hA5) begin
                errors++;
                $display("FAIL full_latency%0d got ok=%b tvalid=%b tdata=%h required 1/1/a5",
                         i, ok, m_tvalid, m_tdata);
            end
            collect(0, pkt, fmt, got);
            checks++;
            if (!got || !fmt || pkt !== exp_pkt(8'h40 + 8'(i), 8'h80 + 8'(i), 4'(i + 1), 0, 0,
                                                2'(i))) begin
                errors++;
                $display("FAIL full_packet%0d got %h required %h", i, pkt,
                         exp_pkt(8'h40 + 8'(i), 8'h80 + 8'(i), 4'(i + 1), 0, 0, 2'(i)));
            end
        end
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            m_tready = 1'b1;
            if (m_tvalid) vcnt++;
            step();
        end
        m_tready = 1'b0;
        checks++;
        if (vcnt != 0 || err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL full_fifth got %0d extra beats err=%0d required 0 err=%0d", vcnt,
                     err_count, model_err);
        end
    endtask

    task automatic test_backpressure();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        push(8'hE1, 8'h7E, 4'd9, acc);
        step(); step();
        send_cpl(4'd9, 2'b01, ok);
        collect(1, pkt, fmt, got);
        checks++;
        if (!ok || !got || !fmt || pkt !== exp_pkt(8'hE1, 8'h7E, 4'd9, 0, 0, 2'b01)) begin
            errors++;
            $display("FAIL backpressure got %h fmt=%b required %h fmt=1", pkt, fmt,
                     exp_pkt(8'hE1, 8'h7E, 4'd9, 0, 0, 2'b01));
        end
    endtask

    task automatic test_random();
        logic [19:0] q[$];
        logic [19:0] h;
        logic acc, ok, fmt, got;
        logic [31:0] pkt, exp;
        logic [3:0] ct;
        logic [1:0] cr;
        int n;
        for (int round = 0; round < 8; round++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                h = 20'($urandom);
                push(h[19:12], h[11:4], h[3:0], acc);
                q.push_back(h);
            end
            repeat (3) step();
            while (q.size() > 0) begin
                h = q.pop_front();
                if ($urandom_range(0, 3) == 0) begin
                    exp = exp_pkt(h[19:12], h[11:4], h[3:0], 1, 0, 2'b10);
                    model_err = err_inc(model_err, 1);
                    ok = 1'b1;
                end else begin
                    ct = ($urandom_range(0, 3) == 0) ? 4'($urandom) : h[3:0];
                    cr = 2'($urandom);
                    exp = exp_pkt(h[19:12], h[11:4], h[3:0], 0, ct != h[3:0], cr);
                    if (ct != h[3:0]) model_err = err_inc(model_err, 1);
                    send_cpl(ct, cr, ok);
                end
                collect(2, pkt, fmt, got);
                checks++;
                if (!ok || !got || !fmt || pkt !== exp || err_count !== 8'(model_err)) begin
                    errors++;
                    $display("FAIL random_r%0d got %h err=%0d fmt=%b required %h err=%0d",
                             round, pkt, err_count, fmt, exp, model_err);
                end
            end
        end
    endtask

    task automatic test_drop_and_reset();
        logic acc, ok, fmt, got;
        logic [31:0] pkt;
        int vcnt;
        repeat (3) step();
        send_cpl(4'd7, 2'b00, ok);
        model_err = err_inc(model_err, 1);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid) vcnt++;
            step();
        end
        checks++;
        if (!ok || vcnt != 0 || err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL idle_drop got ok=%b beats=%0d err=%0d required 1/0/%0d", ok, vcnt,
                     err_count, model_err);
        end
        // Saturation: every cycle in ST_IDLE drops one completion
        cpl_valid = 1'b1;
        repeat (300) step();
        cpl_valid = 1'b0;
        step();
        model_err = err_inc(model_err, 300);
        checks++;
        if (err_count !== 8'(model_err)) begin
            errors++;
            $display("FAIL err_saturate got %0d required %0d", err_count, model_err);
        end
        // Reset while byte1 is on the bus
        push(8'h77, 8'h88, 4'd9, acc);
        step(); step();
        send_cpl(4'd9, 2'b00, ok);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        checks++;
        if (!ok || m_tvalid !== 1'b1 || m_tdata !== 8'h77) begin
            errors++;
            $display("FAIL reset_setup got tvalid=%b tdata=%h required 1/77", m_tvalid, m_tdata);
        end
        bus_reset = 1'b1;
        step();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || err_count !== 8'h00
            || req_ready !== 1'b0 || cpl_ready !== 1'b0) begin
            errors++;
            $display("FAIL midpkt_reset got v=%b l=%b err=%0d rr=%b cr=%b required all 0",
                     m_tvalid, m_tlast, err_count, req_ready, cpl_ready);
        end
        bus_reset = 1'b0;
        model_err = 0;
        step();
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            m_tready = 1'b1;
            if (m_tvalid) vcnt++;
            step();
        end
        m_tready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || vcnt != 0 || err_count !== 8'h00) begin
            errors++;
            $display("FAIL queue_flushed got rr=%b beats=%0d err=%0d required 1/0/0", req_ready,
                     vcnt, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_mismatch();
        test_full();
        test_backpressure();
        test_random();
        test_drop_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
